bitwise_logic_unit: RTL

Parametrised, pipelined bitwise logic unit: applies one of eight 3-operand logic functions to WIDTH-bit vectors and returns the result with zero/parity flags. It is the vector, registered successor of the single-bit and/or/xor gate network. It sits between a valid/ready producer and consumer and sustains one operation per cycle under back-pressure.

---
 rtl/blu_pkg.sv | 19 +
 rtl/blu_op_core.sv | 35 +++
 rtl/bitwise_logic_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/blu_pkg.sv
// Shared types for the bitwise logic unit.
//   blu_op_e  : 3-bit function select, OP_AND..OP_MUX
//   BLU_OP_W  : width of the function select
package blu_pkg;

    localparam int unsigned BLU_OP_W = 3;

    typedef enum logic [BLU_OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_AOX  = 3'd6,
        OP_MUX  = 3'd7
    } blu_op_e;

endpackage : blu_pkg

// File: rtl/blu_op_core.sv
// Combinational function core of the bitwise logic unit.
// Ports:
//   a, b, c : WIDTH-bit operands (c only used by AOX and MUX)
//   op      : function select (blu_op_e)
//   result  : WIDTH-bit bitwise function output
module blu_op_core
    import blu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  blu_op_e          op,
    output logic [WIDTH-1:0] result
);

    // Function select
    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
            OP_AOX:  result = (a & b) ^ (b | c);
            // per-bit select: a where c=1, b where c=0
            OP_MUX:  result = (a & c) | (b & ~c);
            default: result = '0;
        endcase
    end

endmodule : blu_op_core

// File: rtl/bitwise_logic_unit.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides.
// S1 holds the accepted operands, S2 holds result/zero/parity.
// Optional feature macro: BLU_PARITY_EN (registered ^result on parity;
// when undefined parity is tied 0 and no reduction logic exists).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : input handshake (in_ready combinational from out_ready)
//   a, b, c, op         : operands and function select
//   out_valid/out_ready : output handshake
//   result, zero, parity: registered function output and flags
module bitwise_logic_unit
    import blu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [WIDTH-1:0]    c,
    input  logic [BLU_OP_W-1:0] op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                parity
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [WIDTH-1:0] s1_c_q, s1_c_d;
    blu_op_e          s1_op_q, s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic             s2_zero_q, s2_zero_d;

    logic             s2_free;
    logic             s1_adv;
    logic             in_fire;
    logic [WIDTH-1:0] core_result;

    // Handshake: S2 can take new data if empty or being drained this cycle
    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign in_fire  = in_valid && in_ready;

    blu_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .c      (s1_c_q),
        .op     (s1_op_q),
        .result (core_result)
    );

    // Next-state for both stages; data registers hold unless loaded
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_c_d      = s1_c_q;
        s1_op_d     = s1_op_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_zero_d   = s2_zero_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = b;
            s1_c_d     = c;
            s1_op_d    = blu_op_e'(op);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d  = 1'b1;
            s2_result_d = core_result;
            s2_zero_d   = (core_result == '0);
        end else if (out_ready) begin
            s2_valid_d  = 1'b0;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_c_q      <= '0;
            s1_op_q     <= OP_AND;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_zero_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_c_q      <= s1_c_d;
            s1_op_q     <= s1_op_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_zero_q   <= s2_zero_d;
        end
    end

`ifdef BLU_PARITY_EN
    logic s2_parity_q, s2_parity_d;

    // Parity is captured alongside result
    always_comb begin
        s2_parity_d = s2_parity_q;
        if (s1_adv) begin
            s2_parity_d = ^core_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_parity_q <= 1'b0;
        end else begin
            s2_parity_q <= s2_parity_d;
        end
    end

    assign parity = s2_parity_q;
`else
    assign parity = 1'b0;
`endif

    assign out_valid = s2_valid_q;
    assign result    = s2_result_q;
    assign zero      = s2_zero_q;

endmodule : bitwise_logic_unit
